// File: rtl/wave_scale_pkg.sv
// Shared types and constants for the waveform vertical-scale sequencer.
// Clipping of out-of-range samples is enabled by the WAVE_SCALE_CLIP_EN macro.
package wave_scale_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  localparam logic [2:0] SCALE_MIN = 3'd0;
  localparam logic [2:0] SCALE_MAX = 3'd7;

  localparam logic [7:0] RAIL_LO  = 8'd0;
  localparam logic [7:0] RAIL_HI  = 8'd255;
  localparam logic [7:0] MIDPOINT = 8'd127;

  // Samples above the offset-binary midpoint saturate high, others low.
  function automatic logic [7:0] clip_rail(input logic [7:0] raw);
    return (raw > MIDPOINT) ? RAIL_HI : RAIL_LO;
  endfunction

endpackage

// File: rtl/wave_scale_ctrl_zoom_reg.sv
// Saturating zoom register: holds the scale to be applied at the next pass.
module zoom_reg
  import wave_scale_pkg::*;
#(
  parameter logic [2:0] SCALE_RESET = 3'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       zoom_in,
  input  logic       zoom_out,
  output logic [2:0] pending_scale
);

  logic [2:0] pending_q;
  logic [2:0] pending_d;

  // NOTE: next-state gets its default first, so no path leaves it unassigned (no latch).
  always_comb begin
    pending_d = pending_q;
    if (zoom_in && !zoom_out && (pending_q != SCALE_MIN)) begin
      pending_d = pending_q - 3'd1;
    end else if (zoom_out && !zoom_in && (pending_q != SCALE_MAX)) begin
      pending_d = pending_q + 3'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= SCALE_RESET;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_scale = pending_q;

endmodule

// File: rtl/wave_scale_ctrl.sv
// Per-frame sequencer: streams sample RAM through the external scaler into the line buffer.
// Define WAVE_SCALE_CLIP_EN to clip out-of-range samples to a rail instead of wrapping.
module wave_scale_ctrl
  import wave_scale_pkg::*;
#(
  parameter int         NUM_SAMPLES = 256,
  parameter int         ADDR_W      = 8,
  parameter logic [2:0] SCALE_RESET = 3'd4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              zoom_in,
  input  logic              zoom_out,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [2:0]        scale,
  output logic [7:0]        sample,
  input  logic [7:0]        scaled,
  input  logic              in_range,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   clip_count,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CLIP_MAX  = (ADDR_W + 1)'(NUM_SAMPLES);
  localparam logic [ADDR_W:0]   CLIP_ONE  = (ADDR_W + 1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        scale_q, scale_d;
  logic              flush_q, flush_d;
  logic              v1_q, v1_d;
  logic [ADDR_W-1:0] a1_q, a1_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [ADDR_W:0]   clip_work_q, clip_work_d;
  logic [ADDR_W:0]   clip_count_q, clip_count_d;
  logic              overrun_q, overrun_d;
  logic [2:0]        pending_scale;
  logic [7:0]        wr_data_next;

  zoom_reg #(
    .SCALE_RESET(SCALE_RESET)
  ) u_zoom_reg (
    .clk          (clk),
    .reset        (reset),
    .zoom_in      (zoom_in),
    .zoom_out     (zoom_out),
    .pending_scale(pending_scale)
  );

`ifdef WAVE_SCALE_CLIP_EN
  assign wr_data_next = in_range ? scaled : clip_rail(rd_data);
`else
  assign wr_data_next = scaled;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    scale_d      = scale_q;
    flush_d      = flush_q;
    clip_work_d  = clip_work_q;
    clip_count_d = clip_count_q;
    overrun_d    = overrun_q;

    // Stage 1 is the cycle the RAM data and scaler result are valid for an issued address.
    v1_d      = (state_q == ST_RUN);
    a1_d      = addr_q;
    wr_en_d   = v1_q;
    wr_addr_d = v1_q ? a1_q : wr_addr_q;
    wr_data_d = v1_q ? wr_data_next : wr_data_q;

    if (v1_q && !in_range && (clip_work_q != CLIP_MAX)) begin
      clip_work_d = clip_work_q + CLIP_ONE;
    end

    if ((state_q != ST_IDLE) && frame_start) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d     = ST_RUN;
          scale_d     = pending_scale;
          addr_d      = '0;
          clip_work_d = '0;
          overrun_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (addr_q == LAST_ADDR) begin
          state_d = ST_FLUSH;
          flush_d = 1'b0;
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end
      ST_FLUSH: begin
        flush_d = 1'b1;
        if (flush_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d      = ST_IDLE;
        clip_count_d = clip_work_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      scale_q      <= SCALE_RESET;
      flush_q      <= 1'b0;
      v1_q         <= 1'b0;
      a1_q         <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      clip_work_q  <= '0;
      clip_count_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      scale_q      <= scale_d;
      flush_q      <= flush_d;
      v1_q         <= v1_d;
      a1_q         <= a1_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      clip_work_q  <= clip_work_d;
      clip_count_q <= clip_count_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rd_addr    = addr_q;
  assign scale      = scale_q;
  assign sample     = rd_data;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign clip_count = clip_count_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_wave_scale_ctrl.sv
// Self-checking bench for wave_scale_ctrl: behavioural pass model plus directed literal checks.
module tb_wave_scale_ctrl;

  localparam int N = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       zoom_in;
  logic       zoom_out;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic [2:0] scale;
  logic [7:0] sample;
  logic [7:0] scaled;
  logic       in_range;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic [8:0] clip_count;
  logic       overrun;

  wave_scale_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .zoom_in    (zoom_in),
    .zoom_out   (zoom_out),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .scale      (scale),
    .sample     (sample),
    .scaled     (scaled),
    .in_range   (in_range),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .clip_count (clip_count),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Sample RAM with one-cycle read latency.
  logic [7:0] mem [N];
  always @(posedge clk) rd_data <= mem[rd_addr];

  // Scaler: gain 2^(4-scale) around the offset-binary midpoint.
  function automatic int scale_fn(input int x, input int s);
    int d;
    d = x - 127;
    if (s <= 4) return 127 + d * (1 << (4 - s));
    return 127 + (d >>> (s - 4));
  endfunction

  int y_w;
  always_comb begin
    y_w      = scale_fn(int'(sample), int'(scale));
    scaled   = y_w[7:0];
    in_range = (y_w >= 0) && (y_w <= 255);
  end

  function automatic logic [7:0] exp_wr(input int x, input int s);
    int y;
    y = scale_fn(x, s);
    if (y >= 0 && y <= 255) return y[7:0];
`ifdef WAVE_SCALE_CLIP_EN
    return (x > 127) ? 8'd255 : 8'd0;
`else
    return y[7:0];
`endif
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pass model state.
  int cycle_no = 0;
  int start_cycle = 0;
  bit trk_on = 1'b0;
  int model_pending = 4;
  int model_scale = 4;
  bit model_overrun = 1'b0;
  int exp_clip = 0;
  int cmp_c;

  always @(posedge clk) cycle_no <= cycle_no + 1;

  // Cycle c of a pass: c=1 is the first cycle after frame_start is sampled.
  always @(negedge clk) begin
    if (trk_on) begin
      cmp_c = cycle_no - start_cycle + 1;
      check("busy", busy, cmp_c <= N + 3);
      check("done", done, cmp_c == N + 3);
      check("wr_en", wr_en, (cmp_c >= 3) && (cmp_c <= N + 2));
      check("rd_addr", rd_addr, (cmp_c <= N) ? cmp_c - 1 : N - 1);
      check("scale", scale, model_scale);
      check("overrun", overrun, model_overrun);
      if (cmp_c >= 3 && cmp_c <= N + 2) begin
        check("wr_addr", wr_addr, cmp_c - 3);
        check("wr_data", wr_data, exp_wr(int'(mem[cmp_c - 3]), model_scale));
      end
      if (cmp_c == N + 4) check("clip_count", clip_count, exp_clip);
    end
  end

  task automatic start_pass();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    model_scale   = model_pending;
    model_overrun = 1'b0;
    start_cycle   = cycle_no;
    exp_clip      = 0;
    for (int a = 0; a < N; a++) begin
      int y;
      y = scale_fn(int'(mem[a]), model_scale);
      if (y < 0 || y > 255) exp_clip++;
    end
    trk_on = 1'b1;
  endtask

  task automatic end_pass();
    do begin
      @(posedge clk); #1;
    end while (cycle_no - start_cycle < N + 4);
    trk_on = 1'b0;
  endtask

  task automatic pulse_zoom(input bit zi, input bit zo);
    @(posedge clk); #1 zoom_in = zi; zoom_out = zo;
    @(posedge clk); #1 zoom_in = 1'b0; zoom_out = 1'b0;
    if (zi && !zo && model_pending > 0) model_pending--;
    else if (zo && !zi && model_pending < 7) model_pending++;
  endtask

  int done_seen;
  int wr_seen;

  initial begin
    reset = 1'b1; frame_start = 1'b0; zoom_in = 1'b0; zoom_out = 1'b0;
    for (int a = 0; a < N; a++) mem[a] = 8'd150;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_scale", scale, 4);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_clip", clip_count, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_data", wr_data, 0);

    // Unity gain, flat 150.
    start_pass();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("lit_p1_wr", wr_data, 150);
    end_pass();
    check("lit_p1_clip", clip_count, 0);

    // One zoom_in: gain 2.
    pulse_zoom(1'b1, 1'b0);
    start_pass();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("lit_p2_wr", wr_data, 173);
    check("lit_p2_scale", scale, 3);
    end_pass();

    // One sample overflows at gain 2.
    mem[10] = 8'd200;
    start_pass();
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("lit_p3_addr", wr_addr, 10);
`ifdef WAVE_SCALE_CLIP_EN
    check("lit_p3_wr", wr_data, 255);
`else
    check("lit_p3_wr", wr_data, 17);
`endif
    end_pass();
    check("lit_p3_clip", clip_count, 1);
    mem[10] = 8'd150;

    // Saturate at 7, then simultaneous pulses leave it there.
    repeat (10) pulse_zoom(1'b0, 1'b1);
    pulse_zoom(1'b1, 1'b1);
    start_pass();
    @(negedge clk);
    check("lit_p4_scale", scale, 7);
    repeat (40) @(posedge clk);
    pulse_zoom(1'b1, 1'b0);
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    model_overrun = 1'b1;
    end_pass();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_second_pass", busy, 0);
    end
    check("lit_overrun", overrun, 1);

    // Reset at cycle 100 of a pass.
    start_pass();
    repeat (99) @(posedge clk);
    #1 reset = 1'b1;
    trk_on = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    model_pending = 4; model_scale = 4; model_overrun = 1'b0;
    @(negedge clk);
    check("abort_wr_en", wr_en, 0);
    check("abort_busy", busy, 0);
    check("abort_clip", clip_count, 0);
    check("abort_scale", scale, 4);
    check("abort_overrun", overrun, 0);
    done_seen = 0; wr_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (wr_en) wr_seen++;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_no_wr", wr_seen, 0);

    // Ramp at reduced gain, then ramp at gain 4 with clipping at both ends.
    for (int a = 0; a < N; a++) mem[a] = 8'(a);
    pulse_zoom(1'b0, 1'b1);
    start_pass();
    end_pass();
    repeat (3) pulse_zoom(1'b1, 1'b0);
    start_pass();
    end_pass();
    check("lit_ramp_clip", clip_count, 192);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
